// File: rtl/gpu_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM byte master among NUM_MASTERS tiles.
// One transaction in flight; hung reads are forced to a zero-data response after a watchdog timeout.
module gpu_bus_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned ADDR_BITS      = 32,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned IDX_BITS       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_MASTERS*ADDR_BITS-1:0] s_address,
  input  logic [NUM_MASTERS*DATA_BITS-1:0] s_writedata,
  input  logic [NUM_MASTERS-1:0]           s_write,
  input  logic [NUM_MASTERS-1:0]           s_read,
  output logic [NUM_MASTERS-1:0]           s_waitrequest,
  output logic [DATA_BITS-1:0]             s_readdata,
  output logic [NUM_MASTERS-1:0]           s_readdatavalid,
  output logic [ADDR_BITS-1:0]             m_address,
  output logic [DATA_BITS-1:0]             m_writedata,
  output logic                             m_write,
  output logic                             m_read,
  input  logic                             m_waitrequest,
  input  logic [DATA_BITS-1:0]             m_readdata,
  input  logic                             m_readdatavalid,
  output logic [IDX_BITS-1:0]              grant_idx,
  output logic                             timeout_err
);

  localparam int unsigned TMR_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, RESPOND} state_t;

  state_t                 state_q, state_d;
  logic [IDX_BITS-1:0]    grant_q, grant_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [DATA_BITS-1:0]   wdata_q, wdata_d;
  logic [DATA_BITS-1:0]   rdata_q, rdata_d;
  logic                   is_write_q, is_write_d;
  logic [TMR_BITS-1:0]    timer_q, timer_d;
  logic                   terr_q, terr_d;

  logic [NUM_MASTERS-1:0] req;
  logic                   any_req;
  logic [IDX_BITS-1:0]    winner;

  // Search starts just after the last grant so every requester is reached within NUM_MASTERS tries.
  always_comb begin
    req     = s_read | s_write;
    any_req = 1'b0;
    winner  = grant_q;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      int unsigned cand;
      cand = (32'(grant_q) + k) % NUM_MASTERS;
      if (!any_req && req[IDX_BITS'(cand)]) begin
        any_req = 1'b1;
        winner  = IDX_BITS'(cand);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    is_write_d = is_write_q;
    timer_d    = timer_q;
    terr_d     = terr_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d    = winner;
          addr_d     = s_address[32'(winner)*ADDR_BITS +: ADDR_BITS];
          wdata_d    = s_writedata[32'(winner)*DATA_BITS +: DATA_BITS];
          is_write_d = s_write[winner];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (!m_waitrequest) begin
          if (is_write_q) begin
            state_d = RESPOND;
          end else if (m_readdatavalid) begin
            rdata_d = m_readdata;
            state_d = RESPOND;
          end else begin
            timer_d = '0;
            state_d = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (m_readdatavalid) begin
          rdata_d = m_readdata;
          state_d = RESPOND;
        end else if (timer_q == TMR_BITS'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          terr_d  = 1'b1;
          state_d = RESPOND;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= IDX_BITS'(NUM_MASTERS - 1);
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      is_write_q <= 1'b0;
      timer_q    <= '0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      is_write_q <= is_write_d;
      timer_q    <= timer_d;
      terr_q     <= terr_d;
    end
  end

  // Outputs decode from registered state only, so there is no input-to-output path.
  always_comb begin
    s_waitrequest   = '1;
    s_readdatavalid = '0;
    m_read          = 1'b0;
    m_write         = 1'b0;
    if (state_q == ISSUE) begin
      m_write = is_write_q;
      m_read  = !is_write_q;
    end
    if (state_q == RESPOND) begin
      s_waitrequest[grant_q] = 1'b0;
      if (!is_write_q) s_readdatavalid[grant_q] = 1'b1;
    end
  end

  assign s_readdata  = rdata_q;
  assign m_address   = addr_q;
  assign m_writedata = wdata_q;
  assign grant_idx   = grant_q;
  assign timeout_err = terr_q;

endmodule
